// File: rtl/wb_if.sv
// Execute/data-memory to writeback bundle, including the register file write port.
interface wb_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] in_rd;
    logic [DATA_WIDTH-1:0] in_result;
    logic                  in_is_load;
    logic [2:0]            in_funct3;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  wen;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wb_done;

    modport master (
        output in_valid, in_rd, in_result, in_is_load, in_funct3, mem_rvalid, mem_rdata,
        input  in_ready, wen, waddr, wdata, wb_done
    );

    modport slave (
        input  in_valid, in_rd, in_result, in_is_load, in_funct3, mem_rvalid, mem_rdata,
        output in_ready, wen, waddr, wdata, wb_done
    );
endinterface

// File: rtl/wb_unit.sv
// Writeback stage: registered single-cycle register file write for ALU results and formatted loads.
// Optional retire counter enabled with `define WB_RETIRE_CNT_EN.
module wb_unit #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
`ifdef WB_RETIRE_CNT_EN
    output logic [63:0] retire_cnt,
`endif
    wb_if.slave         bus
);
    typedef enum logic [1:0] {IDLE, WAIT_MEM, WRITE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] rd_q, rd_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [1:0]            off_q, off_d;
    logic                  wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  accept;

    assign bus.in_ready = (state_q != WAIT_MEM);
    assign bus.wen      = wen_q;
    assign bus.waddr    = waddr_q;
    assign bus.wdata    = wdata_q;
    assign bus.wb_done  = (state_q == WRITE);
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        byte_sel = bus.mem_rdata[7:0];
        case (off_q)
            2'd1:    byte_sel = bus.mem_rdata[15:8];
            2'd2:    byte_sel = bus.mem_rdata[23:16];
            2'd3:    byte_sel = bus.mem_rdata[31:24];
            default: byte_sel = bus.mem_rdata[7:0];
        endcase
        half_sel = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}}, half_sel};
            default: load_data = bus.mem_rdata;  // lw and undefined encodings
        endcase
    end

    always_comb begin
        state_d  = state_q;
        rd_d     = rd_q;
        funct3_d = funct3_q;
        off_d    = off_q;
        wen_d    = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        case (state_q)
            WAIT_MEM: begin
                if (bus.mem_rvalid) begin
                    state_d = WRITE;
                    wen_d   = (rd_q != '0);
                    waddr_d = rd_q;
                    wdata_d = load_data;
                end
            end
            default: begin
                if (accept && bus.in_is_load) begin
                    state_d  = WAIT_MEM;
                    rd_d     = bus.in_rd;
                    funct3_d = bus.in_funct3;
                    off_d    = bus.in_result[1:0];
                end else if (accept) begin
                    state_d = WRITE;
                    wen_d   = (bus.in_rd != '0);
                    waddr_d = bus.in_rd;
                    wdata_d = bus.in_result;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rd_q     <= '0;
            funct3_q <= '0;
            off_q    <= '0;
            wen_q    <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            rd_q     <= rd_d;
            funct3_q <= funct3_d;
            off_q    <= off_d;
            wen_q    <= wen_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_cnt_q, retire_cnt_d;

    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (state_q == WRITE) retire_cnt_d = retire_cnt_q + 64'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) retire_cnt_q <= '0;
        else     retire_cnt_q <= retire_cnt_d;
    end

    assign retire_cnt = retire_cnt_q;
`endif
endmodule

// File: tb/tb_wb_unit.sv
// Randomized bench for wb_unit against a transaction-level writeback model.
module tb_wb_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_cnt;
    wb_unit #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (.clk(clk), .rst(rst), .retire_cnt(retire_cnt), .bus(bus));
`else
    wb_unit #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    int n_vec = 0;
    int n_err = 0;

    // model: a pending load (if any) and the write expected in the current cycle
    bit          m_wait;
    logic [4:0]  m_rd;
    logic [2:0]  m_f3;
    logic [1:0]  m_off;
    bit          e_done, e_wen;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic [63:0] m_cnt;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] load_fmt(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * off[1])) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 32'd128) ? b - 32'd256 : b;
            3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    task automatic model_reset();
        m_wait = 0; m_rd = '0; m_f3 = '0; m_off = '0;
        e_done = 0; e_wen = 0; e_waddr = '0; e_wdata = '0; m_cnt = '0;
    endtask

    // One cycle: check outputs, drive inputs for the coming edge, advance the model.
    task automatic tick(input bit v, input logic [4:0] rd, input logic [31:0] res, input bit ld,
                        input logic [2:0] f3, input bit rv, input logic [31:0] rdata);
        @(negedge clk);
        chk("in_ready", bus.in_ready, !m_wait);
        chk("wen", bus.wen, e_wen);
        chk("wb_done", bus.wb_done, e_done);
        if (e_done) begin
            chk("waddr", bus.waddr, e_waddr);
            chk("wdata", bus.wdata, e_wdata);
        end
`ifdef WB_RETIRE_CNT_EN
        chk("retire_cnt", retire_cnt, m_cnt);
`endif
        m_cnt = m_cnt + (e_done ? 64'd1 : 64'd0);
        bus.in_valid = v; bus.in_rd = rd; bus.in_result = res; bus.in_is_load = ld;
        bus.in_funct3 = f3; bus.mem_rvalid = rv; bus.mem_rdata = rdata;
        e_done = 0; e_wen = 0;
        if (m_wait) begin
            if (rv) begin
                m_wait = 0; e_done = 1; e_wen = (m_rd != 0);
                e_waddr = m_rd; e_wdata = load_fmt(m_f3, m_off, rdata);
            end
        end else if (v) begin
            if (ld) begin
                m_wait = 1; m_rd = rd; m_f3 = f3; m_off = res[1:0];
            end else begin
                e_done = 1; e_wen = (rd != 0); e_waddr = rd; e_wdata = res;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, '0, '0, 0, '0, 0, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 0; bus.mem_rvalid = 0;
        #1;
        chk("rst_ready", bus.in_ready, 1);
        chk("rst_wen", bus.wen, 0);
        chk("rst_done", bus.wb_done, 0);
        chk("rst_waddr", bus.waddr, 0);
        chk("rst_wdata", bus.wdata, 0);
`ifdef WB_RETIRE_CNT_EN
        chk("rst_cnt", retire_cnt, 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic load_case(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] rdata, input logic [31:0] exp);
        tick(1, 5'd9, addr, 1, f3, 0, '0);
        idle(2);
        tick(0, '0, '0, 0, '0, 1, rdata);
        @(posedge clk); #1;
        chk(tag, bus.wdata, exp);
    endtask

    initial begin
        bus.in_valid = 0; bus.in_rd = '0; bus.in_result = '0; bus.in_is_load = 0;
        bus.in_funct3 = '0; bus.mem_rvalid = 0; bus.mem_rdata = '0;
        model_reset();
        do_reset();

        // ALU write and x0 suppression
        tick(1, 5'd5, 32'h1234_5678, 0, '0, 0, '0);
        @(posedge clk); #1;
        chk("alu_wen", bus.wen, 1);
        chk("alu_wdata", bus.wdata, 32'h1234_5678);
        idle(2);
        tick(1, 5'd0, 32'hFFFF_FFFF, 0, '0, 0, '0);
        @(posedge clk); #1;
        chk("x0_wen", bus.wen, 0);
        chk("x0_done", bus.wb_done, 1);
        idle(2);

        // back-to-back ALU ops
        tick(1, 5'd1, 32'h11, 0, '0, 0, '0);
        tick(1, 5'd2, 32'h22, 0, '0, 0, '0);
        tick(1, 5'd3, 32'h33, 0, '0, 0, '0);
        idle(2);

        // load formatting
        load_case("lb", 3'b000, 32'h1000_0002, 32'h0080_0000, 32'hFFFF_FF80);
        load_case("lbu", 3'b100, 32'h1000_0002, 32'h0080_0000, 32'h0000_0080);
        load_case("lh", 3'b001, 32'h1000_0002, 32'h8001_0000, 32'hFFFF_8001);
        load_case("lhu_odd", 3'b101, 32'h1000_0003, 32'h8001_0000, 32'h0000_8001);
        load_case("lb_off3", 3'b000, 32'h1000_0003, 32'h7F00_0000, 32'h0000_007F);
        load_case("lw_undef", 3'b111, 32'h1000_0001, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        idle(1);

        // stray response in IDLE
        tick(0, '0, '0, 0, '0, 1, 32'hFFFF_FFFF);
        idle(2);

        // reset while a load is pending drops it
        tick(1, 5'd7, 32'h2000_0000, 1, 3'b010, 0, '0);
        idle(1);
        do_reset();
        tick(0, '0, '0, 0, '0, 1, 32'hCAFE_F00D);
        idle(2);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] f3s [8];
            bit rv;
            f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
            rv = m_wait ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 9) == 0);
            tick($urandom_range(0, 9) < 6,
                 ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom),
                 $urandom, $urandom_range(0, 9) < 4, f3s[$urandom_range(0, 7)],
                 rv, $urandom);
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
